// File: rtl/bsg_manycore_sdr_test_responder.sv
// Manycore link test endpoint: serves remote loads/stores from a local word memory, returning responses in order.
// Optional error checking is enabled by defining BSG_SDR_RESPONDER_ERROR_CHECK_EN.
module bsg_manycore_sdr_test_responder #(
   parameter int addr_width_p    = 12,
   parameter int data_width_p    = 32,
   parameter int x_cord_width_p  = 4,
   parameter int y_cord_width_p  = 4,
   parameter int lg_mem_els_p    = 8,
   parameter int lg_fifo_depth_p = 2,
   localparam int cord_width_lp     = x_cord_width_p + y_cord_width_p,
   localparam int fwd_pkt_width_lp  = addr_width_p + 2 + 5 + data_width_p + 2 * cord_width_lp,
   localparam int ret_pkt_width_lp  = 2 + data_width_p + 5 + cord_width_lp,
   localparam int rev_ch_width_lp   = ret_pkt_width_lp + 2,
   localparam int link_sif_width_lp = fwd_pkt_width_lp + 2 + rev_ch_width_lp
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         en_i,
   input  logic [link_sif_width_lp-1:0] link_sif_i,
   output logic [link_sif_width_lp-1:0] link_sif_o,
   output logic [31:0]                  received_o,
   output logic [31:0]                  sent_o,
   output logic                         error_o
);

   // link_sif = {fwd.v, fwd.data, fwd.ready_and_rev, rev.v, rev.data, rev.ready_and_rev}
   // fwd packet = {addr, op, reg_id, data, src_y, src_x, y, x}; return = {type, data, reg_id, y, x}
   localparam logic [1:0] e_remote_load   = 2'd0;
   localparam logic [1:0] e_return_credit = 2'd0;
   localparam logic [1:0] e_return_int_wb = 2'd1;

   logic                        fwd_v_li, rev_v_li, rev_ready_li;
   logic [fwd_pkt_width_lp-1:0] fwd_pkt_li;
   logic [addr_width_p-1:0]     req_addr;
   logic [1:0]                  req_op;
   logic [4:0]                  req_reg_id;
   logic [data_width_p-1:0]     req_data;
   logic [y_cord_width_p-1:0]   req_src_y;
   logic [x_cord_width_p-1:0]   req_src_x;
   logic                        unused_bits;

   assign fwd_v_li     = link_sif_i[link_sif_width_lp-1];
   assign fwd_pkt_li   = link_sif_i[link_sif_width_lp-2 -: fwd_pkt_width_lp];
   assign rev_v_li     = link_sif_i[rev_ch_width_lp-1];
   assign rev_ready_li = link_sif_i[0];
   assign {req_addr, req_op, req_reg_id, req_data, req_src_y, req_src_x} =
      fwd_pkt_li[fwd_pkt_width_lp-1:cord_width_lp];
   assign unused_bits = ^{fwd_pkt_li[cord_width_lp-1:0], link_sif_i[rev_ch_width_lp:1], rev_v_li, req_addr};

   logic [lg_fifo_depth_p:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occupancy;
   logic [31:0]                 received_q, received_d, sent_q, sent_d;
   logic                        error_q, error_d;
   logic [data_width_p-1:0]     mem_q [1 << lg_mem_els_p];
   logic [ret_pkt_width_lp-1:0] fifo_q [1 << lg_fifo_depth_p];
   logic                        fifo_full, fifo_empty, fwd_ready, accept, deq, is_load, mem_we;
   logic [lg_mem_els_p-1:0]     mem_idx;
   logic [data_width_p-1:0]     ret_data;
   logic [ret_pkt_width_lp-1:0] ret_pkt, rev_data;
`ifdef BSG_SDR_RESPONDER_ERROR_CHECK_EN
   logic                        is_store, addr_hi_nz;
`endif

   always_comb begin
      occupancy  = wr_ptr_q - rd_ptr_q;
      fifo_full  = occupancy[lg_fifo_depth_p];
      fifo_empty = (occupancy == '0);
      // Ready is also gated by reset so nothing is accepted while reset is held.
      fwd_ready  = reset_n_i & en_i & ~fifo_full;
      accept     = fwd_v_li & fwd_ready;
      deq        = ~fifo_empty & rev_ready_li;
      mem_idx    = req_addr[lg_mem_els_p-1:0];
      is_load    = (req_op == e_remote_load);
`ifdef BSG_SDR_RESPONDER_ERROR_CHECK_EN
      is_store   = (req_op == 2'd1);
      addr_hi_nz = ((req_addr >> lg_mem_els_p) != '0);
      mem_we     = accept & is_store;
      error_d    = error_q | rev_v_li | (accept & (~(is_load | is_store) | addr_hi_nz));
`else
      mem_we     = accept & ~is_load;
      error_d    = 1'b0;
`endif
      ret_data   = is_load ? mem_q[mem_idx] : '0;
      ret_pkt    = {is_load ? e_return_int_wb : e_return_credit, ret_data, req_reg_id, req_src_y, req_src_x};
      rev_data   = fifo_empty ? '0 : fifo_q[rd_ptr_q[lg_fifo_depth_p-1:0]];
      wr_ptr_d   = wr_ptr_q + {{lg_fifo_depth_p{1'b0}}, accept};
      rd_ptr_d   = rd_ptr_q + {{lg_fifo_depth_p{1'b0}}, deq};
      received_d = received_q + {31'd0, accept};
      sent_d     = sent_q + {31'd0, deq};
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         received_q <= '0;
         sent_q     <= '0;
         error_q    <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         received_q <= received_d;
         sent_q     <= sent_d;
         error_q    <= error_d;
      end
   end

   // Storage arrays are deliberately not reset; memory contents survive reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[mem_idx] <= req_data;
      if (accept) fifo_q[wr_ptr_q[lg_fifo_depth_p-1:0]] <= ret_pkt;
   end

   assign link_sif_o = {1'b0, {fwd_pkt_width_lp{1'b0}}, fwd_ready, ~fifo_empty, rev_data, 1'b0};
   assign received_o = received_q;
   assign sent_o     = sent_q;
   assign error_o    = error_q;

endmodule

// File: tb/tb_bsg_manycore_sdr_test_responder.sv
// Directed bench with a queue-based reference model checked every cycle plus literal expectations.
module tb_bsg_manycore_sdr_test_responder;
   localparam int A = 12, DEPTH = 4, RET_W = 47, LINK_W = 118;
   localparam logic [1:0] LD = 2'd0, ST = 2'd1, AMO = 2'd2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic en = 1'b0;
   logic fwd_v = 1'b0;
   logic [1:0] op = '0;
   logic [A-1:0] addr = '0;
   logic [4:0] reg_id = '0;
   logic [31:0] data = '0;
   logic [3:0] src_x = '0, src_y = '0;
   logic rev_v_in = 1'b0, rev_ready = 1'b0;
   logic [LINK_W-1:0] link_sif_i, link_sif_o;
   logic [31:0] received, sent;
   logic error;

   logic o_fwd_v, o_fwd_ready, o_rev_v, o_rev_ready;
   logic [66:0] o_fwd_data;
   logic [RET_W-1:0] o_rev_data;

   always #5 clk = ~clk;

   assign link_sif_i = {fwd_v, addr, op, reg_id, data, src_y, src_x, 8'h00,
                        1'b0, rev_v_in, {RET_W{1'b0}}, rev_ready};
   assign o_fwd_v     = link_sif_o[117];
   assign o_fwd_data  = link_sif_o[116:50];
   assign o_fwd_ready = link_sif_o[49];
   assign o_rev_v     = link_sif_o[48];
   assign o_rev_data  = link_sif_o[47:1];
   assign o_rev_ready = link_sif_o[0];

   bsg_manycore_sdr_test_responder #(
      .addr_width_p(12), .data_width_p(32), .x_cord_width_p(4), .y_cord_width_p(4),
      .lg_mem_els_p(8), .lg_fifo_depth_p(2)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .link_sif_i(link_sif_i),
      .link_sif_o(link_sif_o), .received_o(received), .sent_o(sent), .error_o(error)
   );

   // ---------------- reference model ----------------
   logic [RET_W-1:0] exp_q[$];
   logic [31:0] mdl_mem [256];
   int unsigned exp_recv = 0, exp_sent = 0;
   bit exp_err = 1'b0;

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         exp_q.delete();
         exp_recv = 0;
         exp_sent = 0;
         exp_err  = 1'b0;
      end else begin
         bit acc, deq;
         logic [7:0] idx;
         logic [RET_W-1:0] ret;
         acc = fwd_v && en && (exp_q.size() < DEPTH);
         deq = (exp_q.size() > 0) && rev_ready;
         idx = addr[7:0];
         if (deq) begin
            void'(exp_q.pop_front());
            exp_sent++;
         end
         if (acc) begin
            exp_recv++;
            if (op == LD) ret = {2'd1, mdl_mem[idx], reg_id, src_y, src_x};
            else begin
               ret = {2'd0, 32'h0, reg_id, src_y, src_x};
`ifdef BSG_SDR_RESPONDER_ERROR_CHECK_EN
               if (op == ST) mdl_mem[idx] = data;
`else
               mdl_mem[idx] = data;
`endif
            end
`ifdef BSG_SDR_RESPONDER_ERROR_CHECK_EN
            if (op > ST || addr[A-1:8] != 0) exp_err = 1'b1;
`endif
            exp_q.push_back(ret);
         end
`ifdef BSG_SDR_RESPONDER_ERROR_CHECK_EN
         if (rev_v_in) exp_err = 1'b1;
`endif
      end
   end

   // ---------------- checking ----------------
   int checks = 0, errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected handshake", name);
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("cyc_fwd_ready", o_fwd_ready, reset_n && en && (exp_q.size() < DEPTH));
         chk("cyc_rev_v", o_rev_v, exp_q.size() != 0);
         if (exp_q.size() != 0) chk("cyc_rev_data", o_rev_data, exp_q[0]);
         else chk("cyc_rev_data_idle", o_rev_data, 0);
         chk("cyc_received", received, exp_recv);
         chk("cyc_sent", sent, exp_sent);
         chk("cyc_error", error, exp_err);
         chk("cyc_tied", {o_fwd_v, o_rev_ready, |o_fwd_data}, 0);
      end
   end

   // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
   task automatic drive(input logic [1:0] o, input logic [A-1:0] a, input logic [31:0] d,
                        input logic [4:0] r, input logic [3:0] sx, input logic [3:0] sy);
      op = o; addr = a; data = d; reg_id = r; src_x = sx; src_y = sy; fwd_v = 1'b1;
   endtask

   task automatic send(input logic [1:0] o, input logic [A-1:0] a, input logic [31:0] d,
                       input logic [4:0] r, input logic [3:0] sx, input logic [3:0] sy);
      bit got = 1'b0;
      drive(o, a, d, r, sx, sy);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (o_fwd_ready) begin got = 1'b1; break; end
      end
      if (!got) timeout("send");
      @(posedge clk); #1;
      fwd_v = 1'b0;
   endtask

   task automatic pop_expect(input string name, input logic [RET_W-1:0] exp);
      int n = 0;
      @(negedge clk);
      while (!o_rev_v && n < 20) begin @(negedge clk); n++; end
      if (!o_rev_v) timeout(name);
      else chk(name, o_rev_data, exp);
      rev_ready = 1'b1;
      @(posedge clk); #1;
      rev_ready = 1'b0;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int accepted;
      bit got;
      en = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_rev_v", o_rev_v, 0);
      chk("reset_ready", o_fwd_ready, 1);
      chk("reset_received", received, 0);
      chk("reset_sent", sent, 0);
      chk("reset_error", error, 0);
      @(posedge clk); #1;

      // store then load of the same word
      send(ST, 12'h005, 32'hDEADBEEF, 5'd3, 4'd2, 4'd1);
      send(LD, 12'h005, 32'h0, 5'd7, 4'd3, 4'd4);
      pop_expect("store_credit", {2'd0, 32'h0, 5'd3, 4'd1, 4'd2});
      pop_expect("load_wb", {2'd1, 32'hDEADBEEF, 5'd7, 4'd4, 4'd3});

      // load on the cycle right after a store to the same word
      send(ST, 12'h012, 32'h1, 5'd1, 4'd5, 4'd6);
      send(LD, 12'h012, 32'h0, 5'd2, 4'd5, 4'd6);
      pop_expect("b2b_credit", {2'd0, 32'h0, 5'd1, 4'd6, 4'd5});
      pop_expect("b2b_load", {2'd1, 32'h1, 5'd2, 4'd6, 4'd5});

      // fill the FIFO with returns blocked
      pulse_reset();
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         drive(ST, 12'h020 + A'(i), 32'h100 + i, 5'(i), 4'(i), 4'hA);
         got = 1'b0;
         for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (o_fwd_ready) begin got = 1'b1; break; end
         end
         @(posedge clk); #1;
         if (got) accepted++;
      end
      fwd_v = 1'b0;
      @(negedge clk);
      chk("full_accepted", accepted, 4);
      chk("full_ready", o_fwd_ready, 0);
      chk("full_received", received, 4);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
         pop_expect("full_order", {2'd0, 32'h0, 5'(i), 4'hA, 4'(i)});
      @(negedge clk);
      chk("full_sent", sent, 4);
      @(posedge clk); #1;

      // disable acceptance while draining
      send(ST, 12'h030, 32'h30, 5'd8, 4'd1, 4'd1);
      send(ST, 12'h031, 32'h31, 5'd9, 4'd1, 4'd1);
      en = 1'b0;
      rev_ready = 1'b1;
      drive(ST, 12'h032, 32'h32, 5'd10, 4'd1, 4'd1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("en_off_received", received, 6);
      chk("en_off_sent", sent, 6);
      chk("en_off_ready", o_fwd_ready, 0);
      @(posedge clk); #1;
      fwd_v = 1'b0; rev_ready = 1'b0; en = 1'b1;

      // asynchronous reset with three queued returns
      send(LD, 12'h005, 32'h0, 5'd1, 4'd0, 4'd0);
      send(LD, 12'h012, 32'h0, 5'd2, 4'd0, 4'd0);
      send(LD, 12'h020, 32'h0, 5'd3, 4'd0, 4'd0);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rev_v", o_rev_v, 0);
      chk("async_ready", o_fwd_ready, 0);
      chk("async_received", received, 0);
      chk("async_sent", sent, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      send(LD, 12'h005, 32'h0, 5'd4, 4'd7, 4'd8);
      pop_expect("mem_kept_05", {2'd1, 32'hDEADBEEF, 5'd4, 4'd8, 4'd7});
      send(LD, 12'h020, 32'h0, 5'd5, 4'd7, 4'd8);
      pop_expect("mem_kept_20", {2'd1, 32'h100, 5'd5, 4'd8, 4'd7});

      // unsupported op and stray rev traffic
      send(ST, 12'h007, 32'h1234, 5'd1, 4'd1, 4'd2);
      pop_expect("pre_store", {2'd0, 32'h0, 5'd1, 4'd2, 4'd1});
      send(AMO, 12'h007, 32'hAAAA, 5'd2, 4'd1, 4'd2);
      pop_expect("amo_credit", {2'd0, 32'h0, 5'd2, 4'd2, 4'd1});
      send(LD, 12'h007, 32'h0, 5'd3, 4'd1, 4'd2);
`ifdef BSG_SDR_RESPONDER_ERROR_CHECK_EN
      pop_expect("amo_nowrite", {2'd1, 32'h1234, 5'd3, 4'd2, 4'd1});
      chk("amo_error", error, 1);
`else
      pop_expect("amo_as_store", {2'd1, 32'hAAAA, 5'd3, 4'd2, 4'd1});
      chk("amo_error", error, 0);
`endif
      rev_v_in = 1'b1;
      @(posedge clk); #1;
      rev_v_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
`ifdef BSG_SDR_RESPONDER_ERROR_CHECK_EN
      chk("sticky_error", error, 1);
`else
      chk("sticky_error", error, 0);
`endif
      @(posedge clk); #1;
      pulse_reset();
      @(negedge clk);
      chk("error_cleared", error, 0);
      @(posedge clk); #1;

      // upper address bits ignored for indexing
      send(LD, 12'h105, 32'h0, 5'd6, 4'd9, 4'd3);
      pop_expect("addr_alias", {2'd1, 32'hDEADBEEF, 5'd6, 4'd3, 4'd9});
      @(negedge clk);
`ifdef BSG_SDR_RESPONDER_ERROR_CHECK_EN
      chk("addr_hi_error", error, 1);
`else
      chk("addr_hi_error", error, 0);
`endif
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
